sc_sample_accum: RTL and testbench

//   Shadowcheck lint fixture with real sequential RTL. Buffers 4-bit samples in a small FIFO and sums every COUNT samples.

---
 rtl/sc_sample_accum_pkg.sv | 25 ++
 rtl/sc_sample_accum_fifo.sv | 71 +++++++
 rtl/sc_sample_accum.sv | 101 ++++++++++
 tb/tb_sc_sample_accum.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_sample_accum_pkg.sv
// Shared types and helpers for the sample accumulator.
package sc_pkg;

  // Controller phases: collecting samples, or holding a finished sum for the consumer.
  typedef enum logic {
    SC_ACCUM = 1'b0,
    SC_HOLD  = 1'b1
  } sc_state_t;

  // Working width of the zero-extension helper; callers cast the result down to their sum width.
  localparam int unsigned SC_ZEXT_W = 32;

  // Keep only the low 'width' bits of a sample so that the upper sum bits are guaranteed zero.
  function automatic logic [SC_ZEXT_W-1:0] sc_zext(input logic [SC_ZEXT_W-1:0] sample,
                                                  input int unsigned           width);
    logic [SC_ZEXT_W-1:0] keep_mask;
    if (width >= SC_ZEXT_W) begin
      keep_mask = '1;
    end else begin
      keep_mask = (SC_ZEXT_W'(1) << width) - SC_ZEXT_W'(1);
    end
    return sample & keep_mask;
  endfunction

endpackage

// File: rtl/sc_sample_accum_fifo.sv
// Small synchronous FIFO: per-entry storage registers, wrapping pointers and an occupancy count.
// The head entry is read combinationally so a pop can consume it at the same edge.
module sc_sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] entry_rd [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = level_q;
  assign rdata   = entry_rd[rd_ptr_q];

  // One storage register per entry; each captures write data only when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    // Capture the pushed sample into this entry.
    always_ff @(posedge clk) begin : p_entry_wr
      if (push_ok && (wr_ptr_q == PW'(gi))) begin
        entry_q <= wdata;
      end
    end

    assign entry_rd[gi] = entry_q;
  end

  // Pointer and occupancy bookkeeping; clear and reset empty the FIFO without touching storage.
  always_ff @(posedge clk) begin : p_ptrs
    if (!rst_n || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sc_sample_accum.sv
// Buffers unsigned samples in a FIFO, sums every COUNT of them and offers each sum on a
// valid/ready output. While a sum is waiting the FIFO keeps filling but nothing is popped.
module sc_sample_accum #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned COUNT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [WIDTH+$clog2(COUNT)-1:0]    out_sum,
  input  logic                              out_ready,
  output logic [$clog2(DEPTH+1)-1:0]        fifo_level
);

  import sc_pkg::*;

  localparam int unsigned SUMW = WIDTH + $clog2(COUNT);
  localparam int unsigned CW   = $clog2(COUNT);

  sc_state_t        state_q;
  logic [SUMW-1:0]  acc_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [SUMW-1:0]  out_sum_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SUMW-1:0]  head_ext;
  logic [SUMW-1:0]  acc_plus_head;

  // Inputs are refused during reset and flush so a flush can never race a new sample in.
  assign in_ready  = rst_n && !flush && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = rst_n && !flush && (state_q == SC_ACCUM) && !fifo_empty;

  assign head_ext      = SUMW'(sc_zext(32'(fifo_rdata), WIDTH));
  assign acc_plus_head = acc_q + head_ext;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  sc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accumulate popped samples, publish every COUNT-th total and hold it until the consumer takes it.
  always_ff @(posedge clk) begin : p_ctrl
    if (!rst_n || flush) begin
      state_q     <= SC_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      case (state_q)
        SC_ACCUM: begin
          if (fifo_pop) begin
            if (cnt_q == CW'(COUNT-1)) begin
              out_sum_q   <= acc_plus_head;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= SC_HOLD;
            end else begin
              acc_q <= acc_plus_head;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        SC_HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= SC_ACCUM;
          end
        end
        default: state_q <= SC_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_sample_accum.sv
// Scenario bench for sc_sample_accum: directed scenarios plus a randomized run checked
// against a queue-based model of "sum every COUNT accepted samples, in order".
module tb_sc_sample_accum;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int COUNT = 4;
  localparam int SUMW  = WIDTH + $clog2(COUNT);
  localparam int LW    = $clog2(DEPTH + 1);

  typedef int iq_t[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [SUMW-1:0]  out_sum;
  logic             out_ready = 1'b0;
  logic [LW-1:0]    fifo_level;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  iq_t stim_q;
  iq_t got_q;
  int  valid_cycles;

  always #5 clk = ~clk;

  sc_sample_accum #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .COUNT (COUNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_ready  (out_ready),
    .fifo_level (fifo_level)
  );

  // Reference: each emitted sum is the plain total of the next COUNT accepted samples.
  function automatic iq_t model_sums(iq_t vals);
    iq_t res;
    int  s;
    for (int k = 0; k + COUNT <= vals.size(); k += COUNT) begin
      s = 0;
      for (int j = 0; j < COUNT; j++) s += vals[k + j];
      res.push_back(s);
    end
    return res;
  endfunction

  // Drives stim_q into the DUT for a bounded number of cycles and records every handshaken sum.
  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      in_valid = (stim_q.size() != 0);
      in_data  = (stim_q.size() != 0) ? WIDTH'(stim_q[0]) : '0;
      @(negedge clk);
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_sum));
        $display("sum handshake: sum=%0d level=%0d t=%0t", out_sum, fifo_level, $time);
      end
      if (in_valid && in_ready) void'(stim_q.pop_front());
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== '0) $display("FAIL reset_out_sum got=%0d exp=0", out_sum); else pass_cnt++;
    total_cnt++; if (fifo_level !== '0) $display("FAIL reset_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", in_ready); else pass_cnt++;

    // Reach HOLD with two samples still queued, then reset mid-stream.
    stim_q = '{1, 2, 3, 4, 5, 6};
    got_q.delete(); valid_cycles = 0;
    run(8);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== SUMW'(10)) $display("FAIL hold_out_sum got=%0d exp=10", out_sum); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(2)) $display("FAIL hold_level got=%0d exp=2", fifo_level); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL midreset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== '0) $display("FAIL midreset_out_sum got=%0d exp=0", out_sum); else pass_cnt++;
    total_cnt++; if (fifo_level !== '0) $display("FAIL midreset_level got=%0d exp=0", fifo_level); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrelease_in_ready got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    iq_t vals;
    iq_t exp_q;
    vals = '{1, 2, 3, 4};
    exp_q = model_sums(vals);
    out_ready = 1'b1;
    stim_q = vals; got_q.delete(); valid_cycles = 0;
    run(10);
    total_cnt++; if (got_q.size() != 1) $display("FAIL b2b_count got=%0d exp=1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      total_cnt++; if (got_q[0] != exp_q[0]) $display("FAIL b2b_sum got=%0d exp=%0d", got_q[0], exp_q[0]); else pass_cnt++;
    end
    total_cnt++; if (valid_cycles != 1) $display("FAIL b2b_valid_cycles got=%0d exp=1", valid_cycles); else pass_cnt++;
    total_cnt++; if (fifo_level !== '0) $display("FAIL b2b_level got=%0d exp=0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_max_samples();
    iq_t vals;
    iq_t exp_q;
    vals = '{15, 15, 15, 15};
    exp_q = model_sums(vals);
    out_ready = 1'b1;
    stim_q = vals; got_q.delete(); valid_cycles = 0;
    run(10);
    total_cnt++; if (got_q.size() != 1) $display("FAIL max_count got=%0d exp=1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      total_cnt++; if (got_q[0] != exp_q[0]) $display("FAIL max_sum got=%0d exp=%0d", got_q[0], exp_q[0]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    iq_t vals;
    iq_t exp_q;
    vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    exp_q = model_sums(vals);
    out_ready = 1'b0;
    stim_q = vals; got_q.delete(); valid_cycles = 0;
    run(12);
    total_cnt++; if (stim_q.size() != 0) $display("FAIL bp_accepted left=%0d exp=0", stim_q.size()); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== SUMW'(exp_q[0])) $display("FAIL bp_held_sum got=%0d exp=%0d", out_sum, exp_q[0]); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(DEPTH)) $display("FAIL bp_level got=%0d exp=%0d", fifo_level, DEPTH); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    run(12);
    total_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total_cnt++; if (got_q[k] != exp_q[k]) $display("FAIL bp_sum%0d got=%0d exp=%0d", k, got_q[k], exp_q[k]); else pass_cnt++;
    end
    total_cnt++; if (fifo_level !== '0) $display("FAIL bp_drain_level got=%0d exp=0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    stim_q = '{3, 3}; got_q.delete(); valid_cycles = 0;
    run(4);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'd7;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    total_cnt++; if (fifo_level !== '0) $display("FAIL flush_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    stim_q = '{1, 1, 1, 1};
    run(10);
    total_cnt++; if (got_q.size() != 1) $display("FAIL flush_count got=%0d exp=1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      total_cnt++; if (got_q[0] != 4) $display("FAIL flush_sum got=%0d exp=4", got_q[0]); else pass_cnt++;
    end
  endtask

  task automatic test_push_pop_same_edge();
    iq_t exp_q;
    out_ready = 1'b0;
    stim_q = '{1, 2, 3, 4, 5, 6}; got_q.delete(); valid_cycles = 0;
    run(8);
    total_cnt++; if (fifo_level !== LW'(2)) $display("FAIL pp_setup_level got=%0d exp=2", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL pp_handshake_valid got=%b exp=0", out_valid); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 4'd9;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL pp_in_ready%0d got=%b exp=1", k, in_ready); else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++; if (fifo_level !== LW'(2)) $display("FAIL pp_level%0d got=%0d exp=2", k, fifo_level); else pass_cnt++;
    end
    in_valid = 1'b0; in_data = '0;
    exp_q = model_sums('{5, 6, 9, 9});
    got_q.delete();
    run(8);
    total_cnt++; if (got_q.size() != 1) $display("FAIL pp_count got=%0d exp=1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      total_cnt++; if (got_q[0] != exp_q[0]) $display("FAIL pp_sum got=%0d exp=%0d", got_q[0], exp_q[0]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    iq_t model_in;
    int  exp_sum;
    int  hs_count;
    bit  prev_hold;
    logic [SUMW-1:0] prev_sum;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    hs_count = 0; prev_hold = 1'b0; prev_sum = '0;
    for (int c = 0; c < 430; c++) begin
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = WIDTH'($urandom);
        out_ready = ($urandom_range(0, 2) == 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      total_cnt++; if (in_ready !== (fifo_level != LW'(DEPTH))) $display("FAIL rnd_in_ready c=%0d got=%b level=%0d", c, in_ready, fifo_level); else pass_cnt++;
      if (prev_hold) begin
        total_cnt++; if (out_valid !== 1'b1 || out_sum !== prev_sum) $display("FAIL rnd_hold_stable c=%0d got=%b/%0d exp=1/%0d", c, out_valid, out_sum, prev_sum); else pass_cnt++;
      end
      if (in_valid && in_ready) model_in.push_back(int'(in_data));
      if (out_valid && out_ready) begin
        hs_count++;
        total_cnt++;
        if (model_in.size() < COUNT) begin
          $display("FAIL rnd_sum c=%0d got=%0d exp=<only %0d samples>", c, out_sum, model_in.size());
        end else begin
          exp_sum = 0;
          for (int j = 0; j < COUNT; j++) exp_sum += model_in.pop_front();
          if (int'(out_sum) != exp_sum) $display("FAIL rnd_sum c=%0d got=%0d exp=%0d", c, out_sum, exp_sum);
          else pass_cnt++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      @(posedge clk);
      #1;
    end
    $display("random run: %0d sums handshaken, %0d samples left partial", hs_count, model_in.size());
    total_cnt++; if (hs_count < 10) $display("FAIL rnd_activity got=%0d exp>=10", hs_count); else pass_cnt++;
    total_cnt++; if (fifo_level !== '0) $display("FAIL rnd_drain_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rnd_drain_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (model_in.size() >= COUNT) $display("FAIL rnd_leftover got=%0d exp<%0d", model_in.size(), COUNT); else pass_cnt++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_back_to_back();
    test_max_samples();
    test_backpressure();
    test_flush();
    test_push_pop_same_edge();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
